// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, oversampling ratio, receiver FSM
// encodings and small helpers used by the receiver and its bench.
package uart_pkg;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  localparam int OSR = 16;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  function automatic int uart_div(input int clkfrq, input int baud);
    return clkfrq / (baud * OSR);
  endfunction

  function automatic logic maj3(input logic [2:0] s);
    return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
  endfunction

endpackage

// File: rtl/uart_fifo.sv
// First-word fall-through FIFO; the head entry is always visible on o_rdata.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module uart_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic             w_wr_en;
  logic             w_rd_en;

  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign w_wr_en = i_push && (!o_full || i_pop);
  assign w_rd_en = i_pop && !o_empty;

  assign o_rdata = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_wr_en) begin
        r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
        r_wr_ptr                <= r_wr_ptr + (AW+1)'(1);
      end
      if (w_rd_en) begin
        r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
      end
    end
  end

endmodule

// File: rtl/uart_rx_oversampled.sv
// 16x oversampled UART receiver with mid-bit majority vote, false-start
// rejection, parity/framing/break reporting and an output FIFO.
module uart_rx_oversampled
  import uart_pkg::*;
#(
  parameter int CLKFRQ    = 100000000,
  parameter int BAUDRATE  = 9600,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1,
  parameter int DEPTH     = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 break_det,
  output logic                 valid,
  input  logic                 ready,
  output logic                 overrun,
  input  logic                 clr_overrun,
  output logic [2:0]           dbg_state
);

  localparam int DIV   = uart_div(CLKFRQ, BAUDRATE);
  localparam int DIV_W = (DIV < 2) ? 1 : $clog2(DIV);
  localparam int ENT_W = DATA_BITS + 3;

  localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(DIV - 1);
  localparam logic [3:0]       SAMP_FIRST = 4'(OSR / 2 - 1);
  localparam logic [3:0]       SAMP_LAST  = 4'(OSR / 2 + 1);
  localparam logic [3:0]       BIT_LAST   = 4'(DATA_BITS - 1);

  if (DIV < 2) begin : g_chk_div
    $error("uart_rx_oversampled: CLKFRQ/(BAUDRATE*16) must be at least 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_chk_bits
    $error("uart_rx_oversampled: DATA_BITS must be 5..9");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_chk_par
    $error("uart_rx_oversampled: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_chk_stop
    $error("uart_rx_oversampled: STOP_BITS must be 1 or 2");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_chk_depth
    $error("uart_rx_oversampled: DEPTH must be a power of two >= 2");
  end

  logic             r_rx_meta;
  logic             r_rx_sync;
  logic             r_rx_prev;
  logic             w_fall;

  logic [2:0]       r_state;
  logic [DIV_W-1:0] r_div_cnt;
  logic [3:0]       r_tick_cnt;
  logic [3:0]       w_tick_nxt;
  logic             w_tick;
  logic             w_samp_en;
  logic             w_decide;
  logic [1:0]       r_samp;
  logic             w_bit;

  logic [DATA_BITS-1:0] r_shift;
  logic [3:0]           r_bit_cnt;
  logic                 r_stop_cnt;
  logic                 r_par_err;
  logic                 r_frm_err;
  logic                 w_par_exp;
  logic                 w_last_stop;
  logic                 w_frm_final;
  logic                 w_brk;

  logic             w_push;
  logic             w_pop;
  logic             w_full;
  logic             w_empty;
  logic             w_drop;
  logic [ENT_W-1:0] w_wdata;
  logic [ENT_W-1:0] w_rdata;
  logic             r_overrun;

  // Third flop only remembers the previous synchronised level for edge detection.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_rx_meta <= rx;
      r_rx_sync <= r_rx_meta;
      r_rx_prev <= r_rx_sync;
    end
  end

  assign w_fall = r_rx_prev & ~r_rx_sync;

  assign w_tick     = (r_state != ST_IDLE) && (r_div_cnt == DIV_LAST);
  assign w_tick_nxt = r_tick_cnt + 4'd1;
  assign w_samp_en  = w_tick && (w_tick_nxt >= SAMP_FIRST) && (w_tick_nxt <= SAMP_LAST);
  assign w_decide   = w_tick && (w_tick_nxt == SAMP_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_div_cnt  <= '0;
      r_tick_cnt <= '0;
    end else if (r_state == ST_IDLE) begin
      r_div_cnt  <= '0;
      r_tick_cnt <= '0;
    end else if (w_tick) begin
      r_div_cnt  <= '0;
      r_tick_cnt <= w_tick_nxt;
    end else begin
      r_div_cnt  <= r_div_cnt + DIV_W'(1);
    end
  end

  // The first two mid-bit samples are held; the third is taken live at the decision tick.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_samp <= 2'b11;
    end else if (r_state == ST_IDLE) begin
      r_samp <= 2'b11;
    end else if (w_samp_en) begin
      r_samp <= {r_samp[0], r_rx_sync};
    end
  end

  assign w_bit = maj3({r_samp, r_rx_sync});

  assign w_par_exp   = (PARITY == PARITY_ODD) ? ~(^r_shift) : ^r_shift;
  assign w_last_stop = (STOP_BITS == 1) ? 1'b1 : r_stop_cnt;
  assign w_frm_final = r_frm_err | ~w_bit;
  assign w_brk       = w_frm_final && (r_shift == '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_IDLE;
      r_shift    <= '0;
      r_bit_cnt  <= '0;
      r_stop_cnt <= 1'b0;
      r_par_err  <= 1'b0;
      r_frm_err  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_fall) begin
            r_state    <= ST_START;
            r_shift    <= '0;
            r_bit_cnt  <= '0;
            r_stop_cnt <= 1'b0;
            r_par_err  <= 1'b0;
            r_frm_err  <= 1'b0;
          end
        end
        ST_START: begin
          if (w_decide) begin
            r_state <= w_bit ? ST_IDLE : ST_DATA;
          end
        end
        ST_DATA: begin
          if (w_decide) begin
            r_shift   <= {w_bit, r_shift[DATA_BITS-1:1]};
            r_bit_cnt <= r_bit_cnt + 4'd1;
            if (r_bit_cnt == BIT_LAST) begin
              r_state <= (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
            end
          end
        end
        ST_PARITY: begin
          if (w_decide) begin
            r_par_err <= (w_bit != w_par_exp);
            r_state   <= ST_STOP;
          end
        end
        ST_STOP: begin
          // Leave at the last stop sample so a back-to-back start edge is not missed.
          if (w_decide) begin
            if (!w_bit) begin
              r_frm_err <= 1'b1;
            end
            r_stop_cnt <= 1'b1;
            if (w_last_stop) begin
              r_state <= ST_IDLE;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign w_push  = (r_state == ST_STOP) && w_decide && w_last_stop;
  assign w_wdata = {r_shift, r_par_err, w_frm_final, w_brk};
  assign w_pop   = valid & ready;
  assign w_drop  = w_push & w_full & ~w_pop;

  uart_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (reset),
    .i_push  (w_push),
    .i_wdata (w_wdata),
    .i_pop   (w_pop),
    .o_rdata (w_rdata),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // A drop in the same cycle as a clear keeps the flag set.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_overrun <= 1'b0;
    end else if (w_drop) begin
      r_overrun <= 1'b1;
    end else if (clr_overrun) begin
      r_overrun <= 1'b0;
    end
  end

  assign {data, parity_err, frame_err, break_det} = w_rdata;
  assign valid     = ~w_empty;
  assign overrun   = r_overrun;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_uart_rx_oversampled.sv
// Bench for uart_rx_oversampled: three receivers (8N1, 7E1, 8N2) at 16x of
// 10 kBd on a 1.6 MHz clock, fed serial frames and checked through queues.
module tb_uart_rx_oversampled;
  import uart_pkg::*;

  localparam int CLKFRQ  = 1600000;
  localparam int BAUD    = 10000;
  localparam int BIT_CLK = 160;

  // Clock / reset
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic rx0 = 1'b1, rx1 = 1'b1, rx2 = 1'b1;
  logic ready0 = 1'b1, ready1 = 1'b1, ready2 = 1'b1;
  logic clr0 = 1'b0, clr1 = 1'b0, clr2 = 1'b0;
  logic [7:0] data0, data2;
  logic [6:0] data1;
  logic pe0, fe0, bd0, v0, ov0;
  logic pe1, fe1, bd1, v1, ov1;
  logic pe2, fe2, bd2, v2, ov2;
  logic [2:0] st0, st1, st2;

  uart_rx_oversampled #(.CLKFRQ(CLKFRQ), .BAUDRATE(BAUD), .DATA_BITS(8), .PARITY(0),
                        .STOP_BITS(1), .DEPTH(4)) u_8n1 (
    .clk(clk), .reset(rst_n), .rx(rx0), .data(data0), .parity_err(pe0), .frame_err(fe0),
    .break_det(bd0), .valid(v0), .ready(ready0), .overrun(ov0), .clr_overrun(clr0),
    .dbg_state(st0));

  uart_rx_oversampled #(.CLKFRQ(CLKFRQ), .BAUDRATE(BAUD), .DATA_BITS(7), .PARITY(1),
                        .STOP_BITS(1), .DEPTH(4)) u_7e1 (
    .clk(clk), .reset(rst_n), .rx(rx1), .data(data1), .parity_err(pe1), .frame_err(fe1),
    .break_det(bd1), .valid(v1), .ready(ready1), .overrun(ov1), .clr_overrun(clr1),
    .dbg_state(st1));

  uart_rx_oversampled #(.CLKFRQ(CLKFRQ), .BAUDRATE(BAUD), .DATA_BITS(8), .PARITY(0),
                        .STOP_BITS(2), .DEPTH(4)) u_8n2 (
    .clk(clk), .reset(rst_n), .rx(rx2), .data(data2), .parity_err(pe2), .frame_err(fe2),
    .break_det(bd2), .valid(v2), .ready(ready2), .overrun(ov2), .clr_overrun(clr2),
    .dbg_state(st2));

  // Scoreboard state: entries are {data[8:0], parity_err, frame_err, break_det}
  logic [11:0] exp_q0[$];
  logic [11:0] exp_q1[$];
  logic [11:0] exp_q2[$];
  logic        exp_ovr0  = 1'b0;
  bit          ovr_model = 1'b0;
  bit          rand_rdy  = 1'b0;
  int          n_checks  = 0;
  int          n_errors  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model
  function automatic int nbits_of(input int inst);
    return (inst == 1) ? 7 : 8;
  endfunction

  function automatic int par_of(input int inst);
    return (inst == 1) ? 1 : 0;
  endfunction

  function automatic int nstop_of(input int inst);
    return (inst == 2) ? 2 : 1;
  endfunction

  function automatic int qsize(input int inst);
    case (inst)
      0:       return exp_q0.size();
      1:       return exp_q1.size();
      default: return exp_q2.size();
    endcase
  endfunction

  function automatic logic [11:0] exp_entry(input int inst, input logic [8:0] d,
                                            input logic flip, input logic [1:0] stops);
    logic pe, fe, bd;
    pe = (par_of(inst) != 0) && flip;
    fe = (nstop_of(inst) == 2) ? !(stops[0] && stops[1]) : !stops[0];
    bd = fe && (d == 9'd0);
    return {d, pe, fe, bd};
  endfunction

  task automatic push_exp(input int inst, input logic [11:0] e);
    case (inst)
      0: begin
        if (ovr_model && exp_q0.size() == 4) exp_ovr0 = 1'b1;
        else exp_q0.push_back(e);
      end
      1:       exp_q1.push_back(e);
      default: exp_q2.push_back(e);
    endcase
  endtask

  // Driver tasks
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_rx(input int inst, input logic v);
    case (inst)
      0:       rx0 = v;
      1:       rx1 = v;
      default: rx2 = v;
    endcase
  endtask

  task automatic hold_bit(input int inst, input logic v, input int n);
    set_rx(inst, v);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (rand_rdy) ready0 = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic send_char(input int inst, input logic [8:0] data, input logic flip,
                           input logic [1:0] stops, input int period, input int gap);
    logic [8:0] d;
    logic       pbit;
    d = (nbits_of(inst) == 7) ? (data & 9'h07f) : (data & 9'h0ff);
    push_exp(inst, exp_entry(inst, d, flip, stops));
    hold_bit(inst, 1'b0, period);
    for (int i = 0; i < nbits_of(inst); i++) hold_bit(inst, d[i], period);
    if (par_of(inst) != 0) begin
      pbit = 1'($countones(d) % 2);
      if (par_of(inst) == 2) pbit = ~pbit;
      hold_bit(inst, pbit ^ flip, period);
    end
    for (int i = 0; i < nstop_of(inst); i++) hold_bit(inst, stops[i], period);
    hold_bit(inst, 1'b1, gap);
  endtask

  task automatic wait_drain(input int inst, input int budget);
    int n;
    n = 0;
    while (qsize(inst) != 0 && n < budget) begin
      cyc(1);
      n++;
    end
    n_checks++;
    if (qsize(inst) != 0) begin
      n_errors++;
      $display("FAIL drain_%0d: %0d entries never appeared within %0d cycles", inst, qsize(inst), budget);
      case (inst)
        0:       exp_q0.delete();
        1:       exp_q1.delete();
        default: exp_q2.delete();
      endcase
    end
  endtask

  // Monitor
  task automatic pop_check(input int inst, input logic [11:0] act);
    logic [11:0] e;
    bit          have;
    have = 1'b0;
    e    = '0;
    case (inst)
      0: if (exp_q0.size() > 0) begin e = exp_q0.pop_front(); have = 1'b1; end
      1: if (exp_q1.size() > 0) begin e = exp_q1.pop_front(); have = 1'b1; end
      default: if (exp_q2.size() > 0) begin e = exp_q2.pop_front(); have = 1'b1; end
    endcase
    if (!have) begin
      n_checks++;
      n_errors++;
      $display("FAIL unexpected_%0d: got entry %0h with none expected", inst, act);
    end else begin
      check($sformatf("entry_%0d", inst), 32'(act), 32'(e));
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (v0 && ready0) pop_check(0, {1'b0, data0, pe0, fe0, bd0});
      if (v1 && ready1) pop_check(1, {2'b0, data1, pe1, fe1, bd1});
      if (v2 && ready2) pop_check(2, {1'b0, data2, pe2, fe2, bd2});
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors + 1);
    $fatal(1, "watchdog");
  end

  // Main sequence
  initial begin
    int         inst;
    logic [1:0] stops;
    logic       flip;

    cyc(5);
    check("rst_out_8n1", {data0, pe0, fe0, bd0, v0, ov0}, 0);
    check("rst_out_7e1", {data1, pe1, fe1, bd1, v1, ov1}, 0);
    check("rst_out_8n2", {data2, pe2, fe2, bd2, v2, ov2}, 0);
    check("rst_state", {st0, st1, st2}, {ST_IDLE, ST_IDLE, ST_IDLE});
    rst_n = 1'b1;
    cyc(5);
    check("post_rst_valid", {v0, v1, v2}, 0);

    // 8N1 single character
    send_char(0, 9'h0a5, 1'b0, 2'b11, BIT_CLK, 20);
    wait_drain(0, 400);

    // 7E1: good parity, then flipped parity
    send_char(1, 9'h041, 1'b0, 2'b11, BIT_CLK, 20);
    send_char(1, 9'h041, 1'b1, 2'b11, BIT_CLK, 20);
    wait_drain(1, 400);

    // 8N2: low second stop bit, then a 12-bit-time break
    send_char(2, 9'h05a, 1'b0, 2'b01, BIT_CLK, 20);
    wait_drain(2, 400);
    push_exp(2, exp_entry(2, 9'h000, 1'b0, 2'b00));
    hold_bit(2, 1'b0, 12 * BIT_CLK);
    hold_bit(2, 1'b1, 20);
    wait_drain(2, 400);
    cyc(2 * BIT_CLK);

    // False start: 40-clk low pulse
    hold_bit(0, 1'b0, 20);
    check("false_start_entered", 32'(st0), 32'(ST_START));
    hold_bit(0, 1'b0, 20);
    hold_bit(0, 1'b1, 200);
    check("false_start_idle", 32'(st0), 32'(ST_IDLE));
    check("false_start_nopush", 32'(v0), 0);

    // Randomised traffic with baud mismatch and random backpressure on the 8N1 port
    rand_rdy = 1'b1;
    for (int i = 0; i < 12; i++) begin
      inst  = $urandom_range(0, 2);
      flip  = (inst == 1) ? ($urandom_range(0, 2) == 0) : 1'b0;
      stops = 2'b11;
      if (inst != 1 && $urandom_range(0, 4) == 0) stops = 2'($urandom_range(0, 2));
      send_char(inst, 9'($urandom_range(0, 255)), flip, stops,
                $urandom_range(BIT_CLK - 4, BIT_CLK + 4), $urandom_range(10, 60));
    end
    rand_rdy = 1'b0;
    ready0   = 1'b1;
    wait_drain(0, 400);
    wait_drain(1, 400);
    wait_drain(2, 400);

    // Overrun: five back-to-back characters into a 4-deep FIFO with no consumer
    ready0    = 1'b0;
    ovr_model = 1'b1;
    for (int v = 1; v <= 5; v++) send_char(0, 9'(v), 1'b0, 2'b11, BIT_CLK, 0);
    cyc(20);
    ovr_model = 1'b0;
    check("ovr_set", 32'(ov0), 32'(exp_ovr0));
    check("ovr_head", {1'b0, data0, pe0, fe0, bd0, v0}, {exp_q0[0], 1'b1});
    cyc(100);
    check("ovr_head_stable", {1'b0, data0, pe0, fe0, bd0}, 32'(exp_q0[0]));
    ready0 = 1'b1;
    wait_drain(0, 50);
    check("ovr_sticky", 32'(ov0), 32'(exp_ovr0));
    clr0 = 1'b1;
    cyc(1);
    clr0     = 1'b0;
    exp_ovr0 = 1'b0;
    cyc(1);
    check("ovr_cleared", 32'(ov0), 32'(exp_ovr0));

    // Reset mid-frame with one entry buffered
    ready0 = 1'b0;
    send_char(0, 9'h077, 1'b0, 2'b11, BIT_CLK, 50);
    check("pre_rst_valid", 32'(v0), 1);
    hold_bit(0, 1'b0, BIT_CLK);
    for (int b = 0; b < 4; b++) hold_bit(0, b[0], BIT_CLK);
    hold_bit(0, 1'b1, BIT_CLK / 2);
    rst_n = 1'b0;
    exp_q0.delete();
    cyc(3);
    check("mid_rst_out", {data0, v0, ov0, st0}, {8'h00, 1'b0, 1'b0, ST_IDLE});
    rst_n  = 1'b1;
    ready0 = 1'b1;
    cyc(2 * BIT_CLK);
    check("post_rst_empty", 32'(v0), 0);
    send_char(0, 9'h03c, 1'b0, 2'b11, BIT_CLK, 20);
    wait_drain(0, 400);
    cyc(2 * BIT_CLK);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
